// File: rtl/router_sram.sv
// Byte-addressed router buffer: one wide write port storing WRITE_WIDTH contiguous
// bytes per cycle (wrapping at the top), plus READ_WIDTH independent registered byte reads.
module router_sram #(
    parameter int  DEPTH       = 64,
    parameter int  DATA_WIDTH  = 8,
    parameter int  WRITE_WIDTH = 4,
    parameter int  READ_WIDTH  = 2,
    localparam int ADDR_WIDTH  = $clog2(DEPTH * WRITE_WIDTH)
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic                                         i_write_en,
    input  logic                                         i_read_en,
    input  logic [0:WRITE_WIDTH-1][DATA_WIDTH-1:0]       i_data_in,
    input  logic [ADDR_WIDTH-1:0]                        i_write_addr,
    input  logic [0:READ_WIDTH-1][ADDR_WIDTH-1:0]        i_read_addr,
    output logic [0:READ_WIDTH-1][DATA_WIDTH-1:0]        o_data_out
);

    localparam int NUM_ENTRIES = DEPTH * WRITE_WIDTH;
    localparam logic [ADDR_WIDTH:0] NUM_ENTRIES_W = (ADDR_WIDTH + 1)'(NUM_ENTRIES);

    logic [DATA_WIDTH-1:0] mem_reg [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0] wr_addr [WRITE_WIDTH];

    // Start address is always in range and the offset is below NUM_ENTRIES,
    // so a single conditional subtract implements the modulo wrap.
    generate
        for (genvar gi = 0; gi < WRITE_WIDTH; gi++) begin : g_wr_addr
            logic [ADDR_WIDTH:0] sum_full;
            logic [ADDR_WIDTH:0] wrapped;
            assign sum_full = {1'b0, i_write_addr} + (ADDR_WIDTH + 1)'(gi);
            assign wrapped  = (sum_full >= NUM_ENTRIES_W) ? (sum_full - NUM_ENTRIES_W) : sum_full;
            assign wr_addr[gi] = wrapped[ADDR_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (i_write_en) begin
            for (int k = 0; k < WRITE_WIDTH; k++) begin
                mem_reg[wr_addr[k]] <= i_data_in[k];
            end
        end
    end

    // Non-blocking update of mem_reg gives read-before-write on address collisions.
    logic [DATA_WIDTH-1:0] data_out_reg [READ_WIDTH];

    generate
        for (genvar gi = 0; gi < READ_WIDTH; gi++) begin : g_read_lane
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    data_out_reg[gi] <= '0;
                end else if (i_read_en) begin
                    data_out_reg[gi] <= mem_reg[i_read_addr[gi]];
                end
            end
            assign o_data_out[gi] = data_out_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_router_sram.sv
// Directed bench for router_sram: reset, aligned/unaligned/wrapping writes,
// read-before-write collisions, read hold and reset-vs-write priority.
module tb_router_sram;

    logic              clk;
    logic              rst;
    logic              write_en;
    logic              read_en;
    logic [0:3][7:0]   data_in;
    logic [7:0]        write_addr;
    logic [0:1][7:0]   read_addr;
    logic [0:1][7:0]   data_out;

    int checks = 0;
    int errors = 0;

    router_sram dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_write_en   (write_en),
        .i_read_en    (read_en),
        .i_data_in    (data_in),
        .i_write_addr (write_addr),
        .i_read_addr  (read_addr),
        .o_data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected is {lane0, lane1}
    task automatic check(input string tag, input logic [15:0] expected);
        checks++;
        assert (data_out === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, data_out, expected);
        end
        $display("%s: data_out=%h expected=%h", tag, data_out, expected);
    endtask

    task automatic do_write(input logic [31:0] d, input logic [7:0] a);
        write_en   = 1'b1;
        data_in    = d;
        write_addr = a;
        tick();
        write_en   = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a0, input logic [7:0] a1);
        read_en   = 1'b1;
        read_addr = {a0, a1};
        tick();
        read_en   = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        write_en   = 1'b0;
        read_en    = 1'b0;
        data_in    = '0;
        write_addr = '0;
        read_addr  = '0;
        tick();
        rst = 1'b0;
        check("reset_out", 16'h0000);

        do_read(8'd0, 8'd5);
        check("reset_read_0_5", 16'h0000);

        do_write(32'hA1B2C3D4, 8'd0);
        do_read(8'd1, 8'd0);
        check("aligned_read_1_0", 16'hB2A1);
        do_read(8'd3, 8'd2);
        check("aligned_read_3_2", 16'hD4C3);

        do_write(32'h11223344, 8'd6);
        do_read(8'd6, 8'd9);
        check("unaligned_read_6_9", 16'h1144);
        do_read(8'd7, 8'd8);
        check("unaligned_read_7_8", 16'h2233);
        do_read(8'd5, 8'd10);
        check("unaligned_neighbors", 16'h0000);

        // Write and read entry 0 in the same cycle: old data comes back.
        write_en   = 1'b1;
        data_in    = 32'h99989796;
        write_addr = 8'd0;
        read_en    = 1'b1;
        read_addr  = {8'd0, 8'd0};
        tick();
        write_en = 1'b0;
        read_en  = 1'b0;
        check("rbw_old_data", 16'hA1A1);
        do_read(8'd0, 8'd0);
        check("rbw_new_data", 16'h9999);
        do_read(8'd3, 8'd1);
        check("rbw_rest_of_row", 16'h9698);

        do_write(32'h55667788, 8'd254);
        do_read(8'd255, 8'd1);
        check("wrap_read_255_1", 16'h6688);
        do_read(8'd254, 8'd0);
        check("wrap_read_254_0", 16'h5577);
        do_read(8'd2, 8'd2);
        check("wrap_untouched_2", 16'h9797);

        // Read strobe low: address changes must not disturb the output.
        read_en   = 1'b0;
        read_addr = {8'd6, 8'd9};
        tick();
        check("hold_1", 16'h9797);
        read_addr = {8'd255, 8'd7};
        tick();
        check("hold_2", 16'h9797);

        // Reset together with a write and a read: reset wins everywhere.
        rst        = 1'b1;
        write_en   = 1'b1;
        data_in    = 32'hEEDDCCBB;
        write_addr = 8'd20;
        read_en    = 1'b1;
        read_addr  = {8'd255, 8'd6};
        tick();
        rst      = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        check("reset_drops_read", 16'h0000);
        do_read(8'd20, 8'd21);
        check("reset_drops_write", 16'h0000);
        do_read(8'd6, 8'd255);
        check("reset_clears_mem", 16'h0000);

        do_write(32'h01020304, 8'd100);
        do_read(8'd103, 8'd100);
        check("post_reset_write", 16'h0401);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
